// File: rtl/term_ctrl_if.sv
// Key-byte handshake and text-memory write port of the terminal controller.
// master = keyboard side / memory sink, slave = term_ctrl.
interface term_ctrl_if;
    logic [7:0]  key_in;
    logic        key_valid;
    logic        key_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;

    modport master (
        output key_in,
        output key_valid,
        input  key_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  key_in,
        input  key_valid,
        output key_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/term_ctrl.sv
// Text terminal controller: turns keyboard bytes into text-memory writes and cursor moves.
// Define TERM_SCROLL_EN to scroll (advance top_row and clear the new row) instead of wrapping to the top.
module term_ctrl #(
    parameter int COLS = 70,
    parameter int ROWS = 30
) (
    input  logic       clk,
    input  logic       reset,
    term_ctrl_if.slave bus,
    output logic [4:0] top_row,
    output logic [6:0] cur_x,
    output logic [4:0] cur_y,
    output logic       busy
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [6:0] COL_END  = 7'(COLS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [4:0] ROW_END  = 5'(ROWS);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t      state_r, state_nx_s;
    logic [6:0]  cur_x_r, cur_x_nx_s;
    logic [4:0]  cur_y_r, cur_y_nx_s;
    logic [4:0]  line_r, line_nx_s;
    logic [4:0]  top_row_r, top_row_nx_s;
    logic [6:0]  clr_x_r, clr_x_nx_s;
    logic [4:0]  clr_y_r, clr_y_nx_s;
    logic        mem_we_r, mem_we_nx_s;
    logic [11:0] mem_addr_r, mem_addr_nx_s;
    logic [7:0]  mem_wdata_r, mem_wdata_nx_s;
    logic        key_ready_r;
    logic        busy_r;
    logic        newline_s;
    logic [6:0]  back_x_s;

    // Row arithmetic wraps at ROWS, not at the 5-bit field width.
    function automatic logic [4:0] next_row(input logic [4:0] row);
        if (row == LAST_ROW) begin
            next_row = 5'd0;
        end else begin
            next_row = row + 5'd1;
        end
    endfunction

    assign back_x_s      = cur_x_r - 7'd1;
    assign bus.key_ready = key_ready_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign top_row       = top_row_r;
    assign cur_x         = cur_x_r;
    assign cur_y         = cur_y_r;
    assign busy          = busy_r;

    // Next-state, cursor and write-port decode.
    always_comb begin
        state_nx_s     = state_r;
        cur_x_nx_s     = cur_x_r;
        cur_y_nx_s     = cur_y_r;
        line_nx_s      = line_r;
        top_row_nx_s   = top_row_r;
        clr_x_nx_s     = clr_x_r;
        clr_y_nx_s     = clr_y_r;
        mem_we_nx_s    = 1'b0;
        mem_addr_nx_s  = mem_addr_r;
        mem_wdata_nx_s = mem_wdata_r;
        newline_s      = 1'b0;

        case (state_r)
            INIT: begin
                // clr_y reaching ROWS marks the whole screen as written.
                if (clr_y_r == ROW_END) begin
                    state_nx_s = IDLE;
                end else begin
                    mem_we_nx_s    = 1'b1;
                    mem_addr_nx_s  = {clr_x_r, clr_y_r};
                    mem_wdata_nx_s = 8'h00;
                    if (clr_x_r == LAST_COL) begin
                        clr_x_nx_s = 7'd0;
                        clr_y_nx_s = clr_y_r + 5'd1;
                    end else begin
                        clr_x_nx_s = clr_x_r + 7'd1;
                    end
                end
            end
            CLEAR: begin
                if (clr_x_r == COL_END) begin
                    state_nx_s = IDLE;
                end else begin
                    mem_we_nx_s    = 1'b1;
                    mem_addr_nx_s  = {clr_x_r, clr_y_r};
                    mem_wdata_nx_s = 8'h00;
                    clr_x_nx_s     = clr_x_r + 7'd1;
                end
            end
            IDLE: begin
                if (bus.key_valid && key_ready_r) begin
                    if ((bus.key_in >= 8'h20) && (bus.key_in <= 8'h7E)) begin
                        mem_we_nx_s    = 1'b1;
                        mem_addr_nx_s  = {cur_x_r, cur_y_r};
                        mem_wdata_nx_s = bus.key_in;
                        if (cur_x_r == LAST_COL) begin
                            newline_s = 1'b1;
                        end else begin
                            cur_x_nx_s = cur_x_r + 7'd1;
                        end
                    end else if (bus.key_in == 8'h0D) begin
                        newline_s = 1'b1;
                    end else if (bus.key_in == 8'h08) begin
                        if (cur_x_r != 7'd0) begin
                            cur_x_nx_s     = back_x_s;
                            mem_we_nx_s    = 1'b1;
                            mem_addr_nx_s  = {back_x_s, cur_y_r};
                            mem_wdata_nx_s = 8'h00;
                        end else begin
                            cur_x_nx_s = cur_x_r;
                        end
                    end else begin
                        cur_x_nx_s = cur_x_r;
                    end

                    if (newline_s) begin
                        cur_x_nx_s = 7'd0;
                        cur_y_nx_s = next_row(cur_y_r);
                        if (line_r == LAST_ROW) begin
`ifdef TERM_SCROLL_EN
                            top_row_nx_s = next_row(top_row_r);
                            state_nx_s   = CLEAR;
                            clr_x_nx_s   = 7'd0;
                            clr_y_nx_s   = next_row(cur_y_r);
`else
                            line_nx_s = 5'd0;
`endif
                        end else begin
                            line_nx_s = line_r + 5'd1;
                        end
                    end else begin
                        line_nx_s = line_r;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = INIT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= INIT;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Cursor, clear counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_x_r     <= 7'd0;
            cur_y_r     <= 5'd0;
            line_r      <= 5'd0;
            top_row_r   <= 5'd0;
            clr_x_r     <= 7'd0;
            clr_y_r     <= 5'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 12'd0;
            mem_wdata_r <= 8'd0;
            key_ready_r <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            cur_x_r     <= cur_x_nx_s;
            cur_y_r     <= cur_y_nx_s;
            line_r      <= line_nx_s;
            top_row_r   <= top_row_nx_s;
            clr_x_r     <= clr_x_nx_s;
            clr_y_r     <= clr_y_nx_s;
            mem_we_r    <= mem_we_nx_s;
            mem_addr_r  <= mem_addr_nx_s;
            mem_wdata_r <= mem_wdata_nx_s;
            key_ready_r <= (state_nx_s == IDLE);
            busy_r      <= (state_nx_s != IDLE);
        end
    end

endmodule

// File: tb/tb_term_ctrl.sv
// Self-checking bench for term_ctrl: randomized keys against a cursor/write-list model.
// Follows TERM_SCROLL_EN the same way the design does.
module tb_term_ctrl;
    localparam int COLS = 70;
    localparam int ROWS = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] top_row;
    logic [6:0] cur_x;
    logic [4:0] cur_y;
    logic       busy;

    term_ctrl_if bus_if ();

    term_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .top_row (top_row),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: cursor, logical line, top row and pending writes {x, y, data}.
    int          m_x, m_y, m_line, m_top;
    logic [19:0] exp_q[$];
    logic [19:0] mon_exp;

    task automatic model_reset();
        m_x = 0; m_y = 0; m_line = 0; m_top = 0;
        exp_q.delete();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                exp_q.push_back({7'(x), 5'(y), 8'h00});
    endtask

    task automatic model_newline();
        m_x = 0;
        m_y = (m_y + 1) % ROWS;
        if (m_line == ROWS - 1) begin
`ifdef TERM_SCROLL_EN
            m_top = (m_top + 1) % ROWS;
            for (int c = 0; c < COLS; c++) exp_q.push_back({7'(c), 5'(m_y), 8'h00});
`else
            m_line = 0;
`endif
        end else begin
            m_line = m_line + 1;
        end
    endtask

    task automatic model_key(input logic [7:0] k);
        if (k >= 8'h20 && k <= 8'h7E) begin
            exp_q.push_back({7'(m_x), 5'(m_y), k});
            if (m_x == COLS - 1) model_newline();
            else m_x = m_x + 1;
        end else if (k == 8'h0D) begin
            model_newline();
        end else if (k == 8'h08 && m_x > 0) begin
            m_x = m_x - 1;
            exp_q.push_back({7'(m_x), 5'(m_y), 8'h00});
        end
    endtask

    // Every write cycle must match the next expected write in order.
    always @(negedge clk) begin
        if (bus_if.mem_we === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write got addr=%h data=%h expected no write", bus_if.mem_addr, bus_if.mem_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus_if.mem_addr, bus_if.mem_wdata} !== mon_exp)
                    $display("FAIL write_order got %h/%h expected %h/%h", bus_if.mem_addr, bus_if.mem_wdata, mon_exp[19:8], mon_exp[7:0]);
                else n_pass++;
            end
        end
    end

    // Offer a byte until accepted; returns with the design one cycle past the accept edge.
    task automatic send_key(input logic [7:0] k, output int waited);
        logic rdy;
        model_key(k);
        bus_if.key_in    = k;
        bus_if.key_valid = 1'b1;
        waited = 0;
        rdy = bus_if.key_ready;
        while (rdy !== 1'b1 && waited < 3000) begin
            @(negedge clk); #1;
            rdy = bus_if.key_ready;
            waited++;
        end
        if (waited >= 3000) begin
            n_checks++;
            $display("FAIL send_timeout got key_ready=0 for %0d cycles expected ready", waited);
        end
        @(negedge clk); #1;
        bus_if.key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (bus_if.key_ready !== 1'b1 && cyc < 3000) begin
            @(negedge clk); #1;
            cyc++;
        end
        if (cyc >= 3000) begin
            n_checks++;
            $display("FAIL idle_timeout got key_ready=%b expected 1", bus_if.key_ready);
        end
    endtask

    // Release reset (caller holds it low) and check the full-screen clear.
    task automatic run_init();
        int   cyc;
        logic prev_we;
        model_reset();
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (bus_if.mem_we !== 1'b1 || bus_if.mem_addr !== 12'h000)
            $display("FAIL init_first got we=%b addr=%h expected we=1 addr=000", bus_if.mem_we, bus_if.mem_addr);
        else n_pass++;
        prev_we = 1'b0;
        cyc = 1;
        while (bus_if.key_ready !== 1'b1 && cyc < 2300) begin
            prev_we = bus_if.mem_we;
            @(negedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc !== 2101) $display("FAIL init_length got ready at cycle %0d expected 2101", cyc);
        else n_pass++;
        n_checks++;
        if (prev_we !== 1'b1 || bus_if.mem_we !== 1'b0)
            $display("FAIL init_ready_edge got prev_we=%b we=%b expected 1,0", prev_we, bus_if.mem_we);
        else n_pass++;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL init_missing got %0d pending expected 0", exp_q.size());
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL init_busy got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata} !== 21'd0)
            $display("FAIL reset_mem got we=%b addr=%h data=%h expected 0", bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata);
        else n_pass++;
        n_checks++;
        if (bus_if.key_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL reset_flags got ready=%b busy=%b expected 0,1", bus_if.key_ready, busy);
        else n_pass++;
        n_checks++;
        if (cur_x !== 7'd0 || cur_y !== 5'd0 || top_row !== 5'd0)
            $display("FAIL reset_cursor got x=%0d y=%0d top=%0d expected 0", cur_x, cur_y, top_row);
        else n_pass++;
        run_init();
    endtask

    task automatic test_print();
        int          waited;
        logic [11:0] a_exp;
        send_key(8'h41, waited);
        n_checks++;
        if (bus_if.mem_we !== 1'b1 || bus_if.mem_addr !== 12'h000 || bus_if.mem_wdata !== 8'h41)
            $display("FAIL print_A got we=%b addr=%h data=%h expected 1/000/41", bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata);
        else n_pass++;
        n_checks++;
        if (cur_x !== 7'd1) $display("FAIL print_A_x got %0d expected 1", cur_x);
        else n_pass++;
        send_key(8'h08, waited);
        a_exp = {7'd69, 5'd0};
        for (int i = 0; i < COLS; i++) begin
            send_key(8'h42, waited);
            if (i == COLS - 1) begin
                n_checks++;
                if (bus_if.mem_we !== 1'b1 || bus_if.mem_addr !== a_exp || bus_if.mem_wdata !== 8'h42)
                    $display("FAIL row_last got we=%b addr=%h data=%h expected 1/%h/42", bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, a_exp);
                else n_pass++;
            end
        end
        n_checks++;
        if (cur_x !== 7'd0 || cur_y !== 5'd1) $display("FAIL row_wrap got x=%0d y=%0d expected 0,1", cur_x, cur_y);
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (bus_if.mem_we !== 1'b0) $display("FAIL row_extra got we=%b expected 0", bus_if.mem_we);
        else n_pass++;
    endtask

    task automatic test_backspace();
        int          waited;
        logic [11:0] a_exp;
        send_key(8'h61, waited);
        send_key(8'h62, waited);
        send_key(8'h63, waited);
        send_key(8'h08, waited);
        a_exp = {7'd2, 5'd1};
        n_checks++;
        if (bus_if.mem_we !== 1'b1 || bus_if.mem_addr !== a_exp || bus_if.mem_wdata !== 8'h00 || cur_x !== 7'd2)
            $display("FAIL back_x3 got we=%b addr=%h data=%h x=%0d expected 1/%h/00/2", bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, cur_x, a_exp);
        else n_pass++;
        send_key(8'h0D, waited);
        n_checks++;
        if (bus_if.mem_we !== 1'b0 || cur_x !== 7'd0 || cur_y !== 5'd2)
            $display("FAIL enter got we=%b x=%0d y=%0d expected 0/0/2", bus_if.mem_we, cur_x, cur_y);
        else n_pass++;
        send_key(8'h08, waited);
        n_checks++;
        if (bus_if.mem_we !== 1'b0 || cur_x !== 7'd0 || cur_y !== 5'd2)
            $display("FAIL back_x0 got we=%b x=%0d y=%0d expected 0/0/2", bus_if.mem_we, cur_x, cur_y);
        else n_pass++;
        send_key(8'h1B, waited);
        n_checks++;
        if (bus_if.mem_we !== 1'b0 || cur_x !== 7'd0 || cur_y !== 5'd2)
            $display("FAIL other_byte got we=%b x=%0d y=%0d expected 0/0/2", bus_if.mem_we, cur_x, cur_y);
        else n_pass++;
    endtask

    task automatic test_random();
        int         waited;
        int         sel;
        logic [7:0] k;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5) k = 8'($urandom_range(32, 126));
            else if (sel == 6) k = 8'h0D;
            else if (sel == 7) k = 8'h08;
            else if (sel == 8) k = 8'($urandom_range(0, 31));
            else k = 8'($urandom_range(127, 255));
            send_key(k, waited);
            n_checks++;
            if (cur_x !== 7'(m_x) || cur_y !== 5'(m_y) || top_row !== 5'(m_top))
                $display("FAIL rand_cursor key=%h got x=%0d y=%0d top=%0d expected %0d/%0d/%0d", k, cur_x, cur_y, top_row, m_x, m_y, m_top);
            else n_pass++;
        end
        wait_idle();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL rand_missing got %0d pending expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_scroll();
        int waited;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        run_init();
        for (int i = 0; i < ROWS - 1; i++) send_key(8'h0D, waited);
        n_checks++;
        if (cur_y !== 5'd29) $display("FAIL scroll_pre got y=%0d expected 29", cur_y);
        else n_pass++;
        send_key(8'h0D, waited);
        n_checks++;
        if (cur_y !== 5'd0 || cur_x !== 7'd0) $display("FAIL scroll_wrap got x=%0d y=%0d expected 0,0", cur_x, cur_y);
        else n_pass++;
`ifdef TERM_SCROLL_EN
        n_checks++;
        if (top_row !== 5'd1 || busy !== 1'b1 || bus_if.key_ready !== 1'b0)
            $display("FAIL scroll_top got top=%0d busy=%b ready=%b expected 1/1/0", top_row, busy, bus_if.key_ready);
        else n_pass++;
        send_key(8'h5A, waited);
        n_checks++;
        if (waited < COLS) $display("FAIL scroll_hold got accept after %0d cycles expected >= %0d", waited, COLS);
        else n_pass++;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL scroll_clear got %0d pending expected 0", exp_q.size());
        else n_pass++;
`else
        n_checks++;
        if (top_row !== 5'd0 || busy !== 1'b0 || bus_if.mem_we !== 1'b0)
            $display("FAIL wrap_top got top=%0d busy=%b we=%b expected 0/0/0", top_row, busy, bus_if.mem_we);
        else n_pass++;
        send_key(8'h5A, waited);
        n_checks++;
        if (waited !== 0 || bus_if.mem_addr !== 12'h000 || bus_if.mem_wdata !== 8'h5A)
            $display("FAIL wrap_write got wait=%0d addr=%h data=%h expected 0/000/5a", waited, bus_if.mem_addr, bus_if.mem_wdata);
        else n_pass++;
`endif
        n_checks++;
        if (cur_x !== 7'd1) $display("FAIL scroll_after got x=%0d expected 1", cur_x);
        else n_pass++;
    endtask

    task automatic test_abort();
        int waited;
        int guard;
`ifdef TERM_SCROLL_EN
        send_key(8'h0D, waited);
        guard = 0;
        while (exp_q.size() > COLS - 35 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        n_checks++;
        if (guard >= 200) $display("FAIL abort_reach got %0d pending expected %0d", exp_q.size(), COLS - 35);
        else n_pass++;
`else
        reset = 1'b0;
        @(negedge clk); #1;
        model_reset();
        reset = 1'b1;
        repeat (1000) @(negedge clk);
        #1;
`endif
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus_if.mem_we !== 1'b0 || busy !== 1'b1 || bus_if.key_ready !== 1'b0)
            $display("FAIL abort_now got we=%b busy=%b ready=%b expected 0/1/0", bus_if.mem_we, busy, bus_if.key_ready);
        else n_pass++;
        n_checks++;
        if (cur_x !== 7'd0 || cur_y !== 5'd0 || top_row !== 5'd0)
            $display("FAIL abort_cursor got x=%0d y=%0d top=%0d expected 0", cur_x, cur_y, top_row);
        else n_pass++;
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
        run_init();
        send_key(8'h41, waited);
        n_checks++;
        if (bus_if.mem_addr !== 12'h000 || bus_if.mem_wdata !== 8'h41 || cur_x !== 7'd1)
            $display("FAIL abort_resume got addr=%h data=%h x=%0d expected 000/41/1", bus_if.mem_addr, bus_if.mem_wdata, cur_x);
        else n_pass++;
    endtask

    initial begin
        reset            = 1'b0;
        bus_if.key_in    = 8'h00;
        bus_if.key_valid = 1'b0;
        test_reset();
        test_print();
        test_backspace();
        test_random();
        test_scroll();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/term_ctrl.md
TERM_CTRL -- requirements
Module: term_ctrl

Interface
REQ-001 SHALL have parameters: COLS, 70, characters per row; ROWS, 30, rows per screen.
REQ-002 SHALL have port: clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: key_in  in  8  ASCII byte from PS/2 decoder; key_valid  in  1  byte offered; key_ready  out  1  byte can be accepted.
REQ-005 SHALL have ports: mem_we  out  1  text-memory write strobe; mem_addr  out  12  write address {x[6:0], y[4:0]}; mem_wdata  out  8  write data.
REQ-006 SHALL have ports: top_row  out  5  physical row shown at the top of the screen; cur_x  out  7  cursor column; cur_y  out  5  cursor physical row; busy  out  1  clear in progress.

Function
REQ-007 SHALL use FSM states INIT, IDLE, CLEAR; key_ready SHALL equal (state==IDLE).
REQ-008 SHALL accept a byte on a rising edge where key_valid && key_ready; a byte offered outside IDLE SHALL remain pending, never dropped.
REQ-009 SHALL register all outputs; a write caused by an accept SHALL assert mem_we for exactly the cycle after the accept edge.
REQ-010 For printable 0x20..0x7E: write key_in at {cur_x, cur_y}; cur_x+1, or a newline if cur_x==COLS-1.
REQ-011 For ENTER 0x0D: newline; mem_we SHALL stay low.
REQ-012 For BACK 0x08 with cur_x>0: cur_x-1 and write 0x00 at {cur_x-1, cur_y}; with cur_x==0: no write, no cursor change.
REQ-013 All other byte values SHALL be consumed with no write and no cursor change.
REQ-014 Newline: cur_x=0; cur_y=(cur_y+1) mod ROWS; logical line counter line=min(line+1, ROWS-1).
REQ-015 A newline taken when line==ROWS-1 SHALL be a scroll (see Configuration).
REQ-016 CLEAR SHALL write 0x00 to columns 0..COLS-1 of the target row, one per cycle (70 consecutive mem_we cycles), then return to IDLE.
REQ-017 INIT SHALL clear all ROWS rows, row 0 first, COLS*ROWS=2100 consecutive writes, then enter IDLE.
REQ-018 busy SHALL be 1 in INIT and CLEAR, otherwise 0.
REQ-019 Arithmetic on cur_y and top_row SHALL wrap mod ROWS (29 -> 0), never mod 32; cur_x SHALL never exceed COLS-1.

Reset
REQ-020 While reset==0: state=INIT; cur_x=0; cur_y=0; line=0; top_row=0; mem_we=0; mem_addr=0; mem_wdata=0; key_ready=0; busy=1.
REQ-021 After release, INIT SHALL begin on the first rising edge; reset asserted mid-INIT or mid-CLEAR SHALL abort immediately with no further writes, and the full INIT SHALL restart.

Configuration
REQ-022 With macro TERM_SCROLL_EN defined, a scroll SHALL set top_row=(top_row+1) mod ROWS, keep line=ROWS-1, and enter CLEAR on the new cur_y row.
REQ-023 Without TERM_SCROLL_EN, a scroll SHALL reset line=0, leave top_row at 0 permanently, cause no clear, and leave old row contents visible until overwritten.

Verification
REQ-024 Release reset, key_valid=0 -> 2100 mem_we cycles of wdata 0x00, first addr {0,0}, last addr {69,29}; key_ready rises on the next cycle.
REQ-025 After INIT, send 'A' (0x41) -> one cycle later mem_we=1, addr={0,0}, wdata=0x41; cur_x=1.
REQ-026 Send 70 bytes of 0x42 -> last write at {69,0}; then cur_x=0, cur_y=1 with no extra write.
REQ-027 From cur_x=3, send 0x08 -> write 0x00 at {2,cur_y}, cur_x=2; from cur_x=0, send 0x08 -> no write, cursor unchanged.
REQ-028 With TERM_SCROLL_EN, send 30 ENTERs -> on the 30th: cur_y=0, top_row=1, 70 zero writes to row 0, key_ready=0 throughout, and a byte held on key_valid is accepted only after the clear finishes.
REQ-029 Assert reset during CLEAR at column 35 -> mem_we=0 immediately; after release, INIT restarts at {0,0}.
